// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state encoding and decode helpers
// for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU: add/sub, logic, shifts, compares.
// Multiply codes yield zero here; codes 12-15 flag illegal.
module alu_core #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             illegal
);
    import alu_pkg::*;

    logic [SHW-1:0] sh;
    logic           lt_s;
    logic           lt_u;

    assign sh   = b[SHW-1:0];
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        c       = '0;
        illegal = 1'b0;
        unique case (op)
            OP_ADD:   c = a + b;
            OP_SUB:   c = a - b;
            OP_AND:   c = a & b;
            OP_OR:    c = a | b;
            OP_XOR:   c = a ^ b;
            OP_SLL:   c = a << sh;
            OP_SRL:   c = a >> sh;
            OP_SRA:   c = WIDTH'($signed(a) >>> sh);
            OP_SLT:   c = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:  c = {{(WIDTH-1){1'b0}}, lt_u};
            OP_MUL,
            OP_MULHU: c = '0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready front end, single-cycle ops via alu_core,
// iterative shift-and-add multiplier, registered results held in DONE.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             out_zero,
    output logic             out_illegal
);
    import alu_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic               mulh;

    logic [WIDTH-1:0]   core_c;
    logic               core_ill;
    logic               accept;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mres;

    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .c       (core_c),
        .illegal (core_ill)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Low half of acc holds the remaining multiplier bits; each step adds
    // the multiplicand into the high half and shifts the pair right.
    assign psum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_nxt = {psum, acc[WIDTH-1:1]};
    assign mres    = mulh ? acc_nxt[2*WIDTH-1:WIDTH]
                          : acc_nxt[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == IDLE): begin
                if (accept)
                    state_nxt = is_mul(in_op) ? BUSY : DONE;
            end
            (state == BUSY): begin
                if (cnt == '0) state_nxt = DONE;
            end
            (state == DONE): begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mulh        <= 1'b0;
            out_c       <= '0;
            out_zero    <= 1'b1;
            out_illegal <= 1'b0;
        end else if (accept) begin
            mcand <= in_a;
            mulh  <= (in_op == OP_MULHU);
            cnt   <= SHW'(WIDTH - 1);
            acc   <= {{WIDTH{1'b0}}, in_b};
            if (!is_mul(in_op)) begin
                out_c       <= core_c;
                out_zero    <= (core_c == '0);
                out_illegal <= core_ill;
            end
        end else if (state == BUSY) begin
            acc <= acc_nxt;
            if (cnt == '0) begin
                out_c       <= mres;
                out_zero    <= (mres == '0);
                out_illegal <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed self-checking bench for alu_seq
// (32-bit instance plus an 8-bit multiply regression instance).
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_c;
    logic        out_zero;
    logic        out_illegal;

    logic        v8 = 1'b0;
    logic        r8;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ov8;
    logic        ordy8 = 1'b0;
    logic [7:0]  c8;
    logic        z8;
    logic        ill8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_c       (out_c),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (v8),
        .in_ready    (r8),
        .in_op       (op8),
        .in_a        (a8),
        .in_b        (b8),
        .out_valid   (ov8),
        .out_ready   (ordy8),
        .out_c       (c8),
        .out_zero    (z8),
        .out_illegal (ill8)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {illegal, result} from plain arithmetic on 64-bit values.
    function automatic logic [32:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        logic        ill;
        int          sh;
        longint      sa;
        longint      sb;
        p   = {32'd0, a} * {32'd0, b};
        sh  = int'(b[4:0]);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        ill = 1'b0;
        case (op)
            4'd0:  r = 32'(64'(a) + 64'(b));
            4'd1:  r = 32'(64'(a) - 64'(b));
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = 32'(64'(a) * (64'd1 << sh));
            4'd6:  r = 32'(64'(a) / (64'd1 << sh));
            4'd7:  begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = p[31:0];
            4'd11: r = p[63:32];
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    task automatic run(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int hold);
        logic [32:0] e;
        int          lat;
        int          elat;
        logic        rdy_seen;
        e    = model(op, a, b);
        elat = (op == 4'd10 || op == 4'd11) ? 33 : 1;
        @(negedge clk);
        chk("idle_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            rdy_seen = rdy_seen | in_ready;
            in_a = $urandom;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(elat));
        chk("busy_ready", rdy_seen, 1'b0);
        chk("done_ready", in_ready, 1'b0);
        chk("out_c", out_c, e[31:0]);
        chk("illegal", out_illegal, e[32]);
        chk("zero", out_zero, e[31:0] == 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_a     = $urandom;
            in_op    = 4'($urandom);
            @(negedge clk);
        end
        if (hold > 0) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_c", out_c, e[31:0]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ret_valid", out_valid, 1'b0);
        chk("ret_ready", in_ready, 1'b1);
    endtask

    task automatic run8(input logic [3:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] exp);
        int lat;
        @(negedge clk);
        v8  = 1'b1;
        op8 = op;
        a8  = a;
        b8  = b;
        @(negedge clk);
        v8  = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        lat = 1;
        while (!ov8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_latency", 64'(lat), 64'd9);
        chk("w8_c", c8, exp);
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        chk("w8_ready", r8, 1'b1);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ov_seen;

        repeat (2) @(negedge clk);
        chk("rst_c", out_c, 32'd0);
        chk("rst_zero", out_zero, 1'b1);
        chk("rst_ill", out_illegal, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", in_ready, 1'b1);

        run(4'd0,  32'hFFFF_FFFF, 32'd1, 0);
        run(4'd7,  32'h8000_0000, 32'h24, 0);
        run(4'd8,  32'hFFFF_FFFF, 32'd1, 0);
        run(4'd9,  32'hFFFF_FFFF, 32'd1, 0);
        run(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(4'd4,  32'h1234_5678, 32'h0F0F_0F0F, 5);
        run(4'd13, 32'hDEAD_BEEF, 32'd7, 1);

        // Reset during a multiply: no result may ever appear.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd10;
        in_a     = 32'd3;
        in_b     = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        ov_seen  = 1'b0;
        repeat (10) begin
            ov_seen = ov_seen | out_valid;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_c", out_c, 32'd0);
        repeat (40) begin
            ov_seen = ov_seen | out_valid;
            @(negedge clk);
        end
        chk("abort_valid", ov_seen, 1'b0);

        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: a = 32'd0;
                1: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run(op, a, b, int'($urandom_range(0, 3)));
        end

        run8(4'd10, 8'h10, 8'h10, 8'h00);
        run8(4'd11, 8'h10, 8'h10, 8'h01);
        run8(4'd11, 8'hFF, 8'hFF, 8'hFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
